// File: rtl/getir_asamasi.sv
// Instruction-fetch stage: owns the PC, addresses the combinational
// instruction memory and loads the returned fields into the IF/ID register
// with a valid/ready handshake. Handles redirects and out-of-range fetches.
module getir_asamasi #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 16,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] adres_o,
    input  logic [6:0]  funct7_i,
    input  logic [4:0]  rs2_i,
    input  logic [4:0]  rs1_i,
    input  logic [2:0]  funct3_i,
    input  logic [4:0]  rd_i,
    input  logic [6:0]  opcode_i,
    input  logic        id_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        id_valid_o,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_pc_o,
    output logic        fault_o,
    output logic [31:0] fetch_count_o
);

    // First byte address past the end of instruction memory.
    localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS * 4);

    logic [31:0] pc_q,    pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic        fault_q, fault_d;
    logic [31:0] count_q, count_d;

    logic        in_range;
    logic        load;
    logic [31:0] mem_instr;
    logic [31:0] redirect_target;

    assign in_range        = (pc_q < IMEM_BYTES);
    assign load            = !redirect_i && in_range && !fault_q && (!valid_q || id_ready_i);
    assign mem_instr       = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
    // Masking keeps the whole input in use while forcing word alignment.
    assign redirect_target = redirect_pc_i & ~32'h0000_0003;

    // Next-state selection: redirect beats load, load beats consume/hold.
    always_comb begin
        // NOTE: every variable gets its hold value first, so no path can leave
        // one unassigned and infer a latch.
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        id_pc_d = id_pc_q;
        fault_d = fault_q;
        count_d = count_q;

        if (redirect_i) begin
            pc_d    = redirect_target;
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            fault_d = 1'b0;
        end else begin
            if (!in_range && !fault_q) begin
                fault_d = 1'b1;
            end
            if (load) begin
                instr_d = mem_instr;
                id_pc_d = pc_q;
                valid_d = 1'b1;
                pc_d    = pc_q + 32'd4;
                count_d = count_q + 32'd1;
            end else if (valid_q && id_ready_i) begin
                // Decode took the entry and nothing replaces it: leave a bubble.
                valid_d = 1'b0;
                instr_d = NOP_INSTR;
            end
        end
    end

    // State register with asynchronous active-high reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            id_pc_q <= 32'h0000_0000;
            fault_q <= 1'b0;
            count_q <= 32'h0000_0000;
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            id_pc_q <= id_pc_d;
            fault_q <= fault_d;
            count_q <= count_d;
        end
    end

    assign adres_o       = pc_q;
    assign id_valid_o    = valid_q;
    assign id_instr_o    = instr_q;
    assign id_pc_o       = id_pc_q;
    assign fault_o       = fault_q;
    assign fetch_count_o = count_q;

endmodule

// File: tb/tb_getir_asamasi.sv
// Directed bench for getir_asamasi: a table of per-cycle vectors with
// hand-computed expectations, plus an asynchronous reset during a stall.
module tb_getir_asamasi;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adres;
    logic [6:0]  funct7;
    logic [4:0]  rs2, rs1, rd;
    logic [2:0]  funct3;
    logic [6:0]  opcode;
    logic        id_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        fault;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    getir_asamasi #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_WORDS (16),
        .NOP_INSTR  (NOP)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .adres_o       (adres),
        .funct7_i      (funct7),
        .rs2_i         (rs2),
        .rs1_i         (rs1),
        .funct3_i      (funct3),
        .rd_i          (rd),
        .opcode_i      (opcode),
        .id_ready_i    (id_ready),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .id_valid_o    (id_valid),
        .id_instr_o    (id_instr),
        .id_pc_o       (id_pc),
        .fault_o       (fault),
        .fetch_count_o (fetch_count)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: a distinct word per address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hBEEF ^ a[15:0], a[15:0] ^ 16'h0513};
    endfunction

    // Combinational memory answering the current address.
    always_comb begin
        {funct7, rs2, rs1, funct3, rd, opcode} = mem_word(adres);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        ready;
        logic        redir;
        logic [31:0] redir_pc;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_adres;
        logic        e_fault;
        logic [31:0] e_count;
    } vec_t;

    vec_t vecs[18];

    task automatic check_state(input string tag, input logic e_valid, input logic [31:0] e_pc,
                               input logic [31:0] e_adres, input logic e_fault,
                               input logic [31:0] e_count);
        check({tag, " valid"}, 32'(id_valid), 32'(e_valid));
        check({tag, " instr"}, id_instr, e_valid ? mem_word(e_pc) : NOP);
        check({tag, " id_pc"}, id_pc, e_pc);
        check({tag, " adres"}, adres, e_adres);
        check({tag, " fault"}, 32'(fault), 32'(e_fault));
        check({tag, " count"}, fetch_count, e_count);
    endtask

    initial begin
        //          rdy  red  target        valid id_pc         adres         flt  count
        vecs[0]  = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h00, 32'h04, 1'b0, 32'd1}; // load 0
        vecs[1]  = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h04, 32'h08, 1'b0, 32'd2};
        vecs[2]  = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h08, 32'h0C, 1'b0, 32'd3};
        vecs[3]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h08, 32'h0C, 1'b0, 32'd3}; // stall
        vecs[4]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h08, 32'h0C, 1'b0, 32'd3};
        vecs[5]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h08, 32'h0C, 1'b0, 32'd3};
        vecs[6]  = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h0C, 32'h10, 1'b0, 32'd4}; // release
        vecs[7]  = '{1'b1, 1'b1, 32'h23, 1'b0, 32'h0C, 32'h20, 1'b0, 32'd4}; // redirect, low bits dropped
        vecs[8]  = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h20, 32'h24, 1'b0, 32'd5};
        vecs[9]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h20, 32'h24, 1'b0, 32'd5};
        vecs[10] = '{1'b0, 1'b1, 32'h38, 1'b0, 32'h20, 32'h38, 1'b0, 32'd5}; // redirect while stalled
        vecs[11] = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h38, 32'h3C, 1'b0, 32'd6};
        vecs[12] = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h3C, 32'h40, 1'b0, 32'd7}; // last word
        vecs[13] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h3C, 32'h40, 1'b1, 32'd7}; // out of range -> fault
        vecs[14] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h3C, 32'h40, 1'b1, 32'd7}; // consume, no load
        vecs[15] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h3C, 32'h40, 1'b1, 32'd7}; // frozen
        vecs[16] = '{1'b1, 1'b1, 32'h0, 1'b0, 32'h3C, 32'h00, 1'b0, 32'd7}; // redirect clears fault
        vecs[17] = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h00, 32'h04, 1'b0, 32'd8}; // fetching resumes

        rst         = 1'b1;
        id_ready    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        #12;
        check_state("reset", 1'b0, 32'h0, 32'h0, 1'b0, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            id_ready    = vecs[i].ready;
            redirect    = vecs[i].redir;
            redirect_pc = vecs[i].redir_pc;
            @(posedge clk);
            #1;
            check_state($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_pc,
                        vecs[i].e_adres, vecs[i].e_fault, vecs[i].e_count);
            @(negedge clk);
        end

        // Stall with a valid entry, then reset asynchronously mid-cycle.
        redirect = 1'b0;
        id_ready = 1'b0;
        @(posedge clk);
        #1;
        check_state("stall", 1'b1, 32'h00, 32'h04, 1'b0, 32'd8);
        #2;
        rst = 1'b1;
        #1;
        check_state("async_rst", 1'b0, 32'h0, 32'h0, 1'b0, 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        id_ready = 1'b1;
        @(posedge clk);
        #1;
        check_state("post_rst", 1'b1, 32'h00, 32'h04, 1'b0, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
